// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between uart_cmd_ctrl and its neighbours: the uart RX/TX FIFOs,
// the 8-bit register bus and the frame error counter.
//   master : the command controller (drives strobes, TX byte, register bus)
//   slave  : FIFOs / register file side
interface uart_cmd_ctrl_if;
  logic [3:0] RX_FIFO_LEVEL;
  logic [7:0] RX_FIFO_Q;
  logic       RX_FIFO_RD_REQ;
  logic       TX_FIFO_FULL;
  logic [7:0] TX_BYTE;
  logic       TX_FIFO_WR_REQ;
  logic [7:0] REG_ADDR;
  logic [7:0] REG_WDATA;
  logic       REG_WR;
  logic       REG_RD;
  logic [7:0] REG_RDATA;
  logic [7:0] ERR_CNT;

  modport master (
    input  RX_FIFO_LEVEL, RX_FIFO_Q, TX_FIFO_FULL, REG_RDATA,
    output RX_FIFO_RD_REQ, TX_BYTE, TX_FIFO_WR_REQ,
           REG_ADDR, REG_WDATA, REG_WR, REG_RD, ERR_CNT
  );

  modport slave (
    output RX_FIFO_LEVEL, RX_FIFO_Q, TX_FIFO_FULL, REG_RDATA,
    input  RX_FIFO_RD_REQ, TX_BYTE, TX_FIFO_WR_REQ,
           REG_ADDR, REG_WDATA, REG_WR, REG_RD, ERR_CNT
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: drains the RX FIFO, parses 5-byte frames
// (SYNC, CMD, ADDR, DATA, CHK), runs register writes/reads and queues
// ACK / NAK / read-data responses into the TX FIFO.
// Ports:
//   CLK   - system clock
//   RESET - asynchronous, active-high reset
//   bus   - uart_cmd_ctrl_if.master: RX/TX FIFO handshakes, register bus,
//           ERR_CNT (frame error counter, saturating)
// All outputs are registered.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 115200
) (
  input  logic            CLK,
  input  logic            RESET,
  uart_cmd_ctrl_if.master bus
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  CMD_WR  = 8'h57;
  localparam logic [7:0]  CMD_RD  = 8'h52;
  localparam logic [7:0]  RSP_ACK = 8'h06;
  localparam logic [7:0]  RSP_NAK = 8'h15;

  typedef enum logic [3:0] {
    HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK,
    EXEC, RD_WAIT, SEND_ACK, SEND_DATA, SEND_NAK
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            cap_q;     // RX_FIFO_Q carries the byte requested last cycle
  logic            rd_ack_q;  // REG_RDATA carries the data for last cycle's REG_RD

  logic            rd_req_q, rd_req_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_wr_q, tx_wr_d;
  logic [7:0]      reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic            reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            timed_out, err_evt;
  logic [7:0]      resp_byte;

  function automatic logic is_rx_state(state_t s);
    return (s == HUNT) || (s == GET_CMD) || (s == GET_ADDR) ||
           (s == GET_DATA) || (s == GET_CHK);
  endfunction

  // State and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= HUNT;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      to_cnt_q    <= '0;
      cap_q       <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      tx_byte_q   <= '0;
      tx_wr_q     <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      to_cnt_q    <= to_cnt_d;
      cap_q       <= rd_req_q;
      rd_ack_q    <= reg_rd_q;
      rd_req_q    <= rd_req_d;
      tx_byte_q   <= tx_byte_d;
      tx_wr_q     <= tx_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rd_ack_q ? bus.REG_RDATA : rdata_q;
    to_cnt_d    = '0;
    rd_req_d    = 1'b0;
    tx_byte_d   = tx_byte_q;
    tx_wr_d     = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    err_cnt_d   = err_cnt_q;
    timed_out   = 1'b0;
    err_evt     = 1'b0;

    resp_byte = RSP_ACK;
    if (state_q == SEND_DATA)     resp_byte = rdata_q;
    else if (state_q == SEND_NAK) resp_byte = RSP_NAK;

    // Inter-byte timeout: only inside a frame, restarted by every capture
    if (is_rx_state(state_q) && (state_q != HUNT) && !cap_q) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) timed_out = 1'b1;
      else                                       to_cnt_d  = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      HUNT: begin
        if (cap_q && (bus.RX_FIFO_Q == SYNC_BYTE)) state_d = GET_CMD;
      end
      GET_CMD: begin
        if (cap_q) begin
          cmd_d   = bus.RX_FIFO_Q;
          state_d = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (cap_q) begin
          addr_d  = bus.RX_FIFO_Q;
          state_d = GET_DATA;
        end
      end
      GET_DATA: begin
        if (cap_q) begin
          data_d  = bus.RX_FIFO_Q;
          state_d = GET_CHK;
        end
      end
      GET_CHK: begin
        if (cap_q) begin
          if (((cmd_q ^ addr_q ^ data_q) != bus.RX_FIFO_Q) ||
              ((cmd_q != CMD_WR) && (cmd_q != CMD_RD))) begin
            err_evt = 1'b1;
            state_d = SEND_NAK;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        reg_addr_d = addr_q;
        if (cmd_q == CMD_WR) begin
          reg_wdata_d = data_q;
          reg_wr_d    = 1'b1;
          state_d     = SEND_ACK;
        end else begin
          reg_rd_d = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // REG_RD is on the bus this cycle; data is taken via rd_ack_q next cycle
        state_d = SEND_ACK;
      end
      SEND_ACK, SEND_DATA, SEND_NAK: begin
        if (tx_wr_q) begin
          // Idle cycle after a write: the full flag lags by one cycle
          state_d = ((state_q == SEND_ACK) && (cmd_q == CMD_RD)) ? SEND_DATA : HUNT;
        end else begin
          tx_byte_d = resp_byte;
          if (!bus.TX_FIFO_FULL) tx_wr_d = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    if (timed_out) begin
      err_evt = 1'b1;
      state_d = HUNT;
    end

    // Fetch only while staying in a receive state, one request per two cycles
    if (is_rx_state(state_q) && is_rx_state(state_d) &&
        (bus.RX_FIFO_LEVEL != 4'd0) && !rd_req_q)
      rd_req_d = 1'b1;

    if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign bus.RX_FIFO_RD_REQ = rd_req_q;
  assign bus.TX_BYTE        = tx_byte_q;
  assign bus.TX_FIFO_WR_REQ = tx_wr_q;
  assign bus.REG_ADDR       = reg_addr_q;
  assign bus.REG_WDATA      = reg_wdata_q;
  assign bus.REG_WR         = reg_wr_q;
  assign bus.REG_RD         = reg_rd_q;
  assign bus.ERR_CNT        = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: models the RX FIFO, TX FIFO and
// register file around the DUT and compares every frame's effects against
// a frame-level reference (checksum/command rules, saturating error count).
module tb_uart_cmd_ctrl;
  localparam int unsigned TO = 200;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Environment state
  int         cyc = 0;
  int         sz, nstb;
  logic       prev_full = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int         tx_cyc[$];
  logic [7:0] wr_addr[$], wr_data[$], rd_addr[$];
  int         wr_cyc[$], rd_cyc[$], rdreq_cyc[$];
  int         excl_viol = 0, full_viol = 0;
  logic [7:0] regmem[256];
  bit         written[256];

  // Reference model state
  logic [7:0] ref_mem[256];
  int         ref_err = 0;

  function automatic logic [7:0] dflt(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  // RX FIFO, TX FIFO and register file models plus strobe monitor
  always @(posedge CLK) begin
    cyc = cyc + 1;
    sz  = rxq.size();
    if (bus.RX_FIFO_RD_REQ) begin
      rdreq_cyc.push_back(cyc);
      if (sz > 0) begin
        bus.RX_FIFO_Q <= rxq.pop_front();
        sz = sz - 1;
      end
    end
    bus.RX_FIFO_LEVEL <= 4'((sz > 15) ? 15 : sz);
    if (bus.TX_FIFO_WR_REQ) begin
      txq.push_back(bus.TX_BYTE);
      tx_cyc.push_back(cyc);
      if (prev_full) full_viol = full_viol + 1;
    end
    prev_full = bus.TX_FIFO_FULL;
    if (bus.REG_WR) begin
      regmem[bus.REG_ADDR] <= bus.REG_WDATA;
      written[bus.REG_ADDR] <= 1'b1;
      wr_addr.push_back(bus.REG_ADDR);
      wr_data.push_back(bus.REG_WDATA);
      wr_cyc.push_back(cyc);
    end
    if (bus.REG_RD) begin
      bus.REG_RDATA <= written[bus.REG_ADDR] ? regmem[bus.REG_ADDR] : dflt(int'(bus.REG_ADDR));
      rd_addr.push_back(bus.REG_ADDR);
      rd_cyc.push_back(cyc);
    end
    nstb = int'(bus.RX_FIFO_RD_REQ) + int'(bus.TX_FIFO_WR_REQ) + int'(bus.REG_WR) + int'(bus.REG_RD);
    if (nstb > 1) excl_viol = excl_viol + 1;
  end

  task automatic clear_logs();
    txq.delete(); tx_cyc.delete();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rd_addr.delete(); rd_cyc.delete(); rdreq_cyc.delete();
  endtask

  task automatic push_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
    rxq.push_back(8'hA5); rxq.push_back(c); rxq.push_back(a);
    rxq.push_back(d);     rxq.push_back(k);
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.TX_FIFO_FULL = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.RX_FIFO_RD_REQ, bus.TX_FIFO_WR_REQ, bus.REG_WR, bus.REG_RD} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000",
        {bus.RX_FIFO_RD_REQ, bus.TX_FIFO_WR_REQ, bus.REG_WR, bus.REG_RD});
    end
    checks++;
    if ({bus.TX_BYTE, bus.REG_ADDR, bus.REG_WDATA} !== 24'h0) begin
      errors++; $display("FAIL reset_data: got %h want 000000", {bus.TX_BYTE, bus.REG_ADDR, bus.REG_WDATA});
    end
    checks++;
    if (bus.ERR_CNT !== 8'h00) begin
      errors++; $display("FAIL reset_err_cnt: got %h want 00", bus.ERR_CNT);
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_write();
    bit ok;
    clear_logs();
    push_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    ref_mem[8'h10] = 8'h3C;
    wait_tx(1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_wait: got timeout want ack"); end
    checks++;
    if (txq.size() != 1 || txq[0] !== 8'h06) begin
      errors++; $display("FAIL write_tx: got %0d bytes first %h want 1 byte 06", txq.size(), txq.size() ? txq[0] : 8'h00);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 8'h10 || wr_data[0] !== 8'h3C || rd_addr.size() != 0) begin
      errors++; $display("FAIL write_reg: got %0d writes addr %h data %h want 1 write 10/3C",
        wr_addr.size(), wr_addr.size() ? wr_addr[0] : 8'h0, wr_data.size() ? wr_data[0] : 8'h0);
    end
    checks++;
    if (bus.ERR_CNT !== 8'(ref_err)) begin
      errors++; $display("FAIL write_err_cnt: got %0d want %0d", bus.ERR_CNT, ref_err);
    end
    if (wr_cyc.size() == 1 && tx_cyc.size() == 1 && rdreq_cyc.size() == 5) begin
      // last byte captured the cycle after its request; REG_WR two cycles later
      checks++;
      if (wr_cyc[0] - (rdreq_cyc[4] + 1) != 2) begin
        errors++; $display("FAIL write_lat_capture: got %0d want 2", wr_cyc[0] - (rdreq_cyc[4] + 1));
      end
      checks++;
      if (tx_cyc[0] - wr_cyc[0] != 1) begin
        errors++; $display("FAIL write_lat_ack: got %0d want 1", tx_cyc[0] - wr_cyc[0]);
      end
    end else begin
      checks++; errors++;
      $display("FAIL write_lat_events: got wr=%0d tx=%0d fetch=%0d want 1/1/5", wr_cyc.size(), tx_cyc.size(), rdreq_cyc.size());
    end
  endtask

  task automatic test_read();
    bit ok;
    clear_logs();
    push_frame(8'h52, 8'h10, 8'h00, 8'h42);
    wait_tx(2, 200, ok);
    checks++;
    if (!ok || txq.size() != 2) begin
      errors++; $display("FAIL read_tx_count: got %0d want 2", txq.size());
    end else begin
      checks++;
      if (txq[0] !== 8'h06 || txq[1] !== ref_mem[8'h10]) begin
        errors++; $display("FAIL read_tx: got %h %h want 06 %h", txq[0], txq[1], ref_mem[8'h10]);
      end
      checks++;
      if (tx_cyc[1] - tx_cyc[0] != 2) begin
        errors++; $display("FAIL read_gap: got %0d want 2", tx_cyc[1] - tx_cyc[0]);
      end
    end
    checks++;
    if (rd_addr.size() != 1 || rd_addr[0] !== 8'h10 || wr_addr.size() != 0) begin
      errors++; $display("FAIL read_reg: got %0d reads addr %h want 1 read 10", rd_addr.size(), rd_addr.size() ? rd_addr[0] : 8'h0);
    end else if (tx_cyc.size() >= 1) begin
      checks++;
      if (tx_cyc[0] - rd_cyc[0] != 2) begin
        errors++; $display("FAIL read_lat_ack: got %0d want 2", tx_cyc[0] - rd_cyc[0]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    bit ok;
    clear_logs();
    push_frame(8'h57, 8'h10, 8'h3C, 8'h00);
    ref_err++;
    wait_tx(1, 200, ok);
    checks++;
    if (txq.size() != 1 || txq[0] !== 8'h15) begin
      errors++; $display("FAIL badchk_tx: got %0d bytes first %h want 1 byte 15", txq.size(), txq.size() ? txq[0] : 8'h0);
    end
    checks++;
    if (wr_addr.size() != 0 || rd_addr.size() != 0) begin
      errors++; $display("FAIL badchk_reg: got %0d wr %0d rd want 0 0", wr_addr.size(), rd_addr.size());
    end
    checks++;
    if (bus.ERR_CNT !== 8'(ref_err)) begin
      errors++; $display("FAIL badchk_err_cnt: got %0d want %0d", bus.ERR_CNT, ref_err);
    end
  endtask

  task automatic test_garbage();
    bit ok;
    clear_logs();
    rxq.push_back(8'h00); rxq.push_back(8'hFF); rxq.push_back(8'h12);
    push_frame(8'h57, 8'h22, 8'h5A, 8'h57 ^ 8'h22 ^ 8'h5A);
    ref_mem[8'h22] = 8'h5A;
    wait_tx(1, 300, ok);
    checks++;
    if (txq.size() != 1 || txq[0] !== 8'h06 || wr_addr.size() != 1 || wr_data[0] !== 8'h5A) begin
      errors++; $display("FAIL garbage_frame: got %0d tx %0d wr want 1 ack 1 write", txq.size(), wr_addr.size());
    end
    checks++;
    if (bus.ERR_CNT !== 8'(ref_err)) begin
      errors++; $display("FAIL garbage_err_cnt: got %0d want %0d", bus.ERR_CNT, ref_err);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] fr[5];
    clear_logs();
    rxq.push_back(8'hA5); rxq.push_back(8'h57);
    ref_err++;
    repeat (TO + 10) @(negedge CLK);
    checks++;
    if (txq.size() != 0 || wr_addr.size() != 0) begin
      errors++; $display("FAIL timeout_silent: got %0d tx %0d wr want 0 0", txq.size(), wr_addr.size());
    end
    checks++;
    if (bus.ERR_CNT !== 8'(ref_err)) begin
      errors++; $display("FAIL timeout_err_cnt: got %0d want %0d", bus.ERR_CNT, ref_err);
    end
    // Next frame with slow but in-limit byte spacing
    fr[0] = 8'hA5; fr[1] = 8'h57; fr[2] = 8'h33; fr[3] = 8'h99; fr[4] = 8'h57 ^ 8'h33 ^ 8'h99;
    ref_mem[8'h33] = 8'h99;
    for (int i = 0; i < 5; i++) begin
      rxq.push_back(fr[i]);
      repeat (TO - 60) @(negedge CLK);
    end
    wait_tx(1, 100, ok);
    checks++;
    if (txq.size() != 1 || txq[0] !== 8'h06 || wr_addr.size() != 1 || wr_addr[0] !== 8'h33) begin
      errors++; $display("FAIL timeout_recover: got %0d tx %0d wr want 1 ack 1 write", txq.size(), wr_addr.size());
    end
    checks++;
    if (bus.ERR_CNT !== 8'(ref_err)) begin
      errors++; $display("FAIL timeout_recover_err: got %0d want %0d", bus.ERR_CNT, ref_err);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    clear_logs();
    bus.TX_FIFO_FULL = 1'b1;
    push_frame(8'h52, 8'h22, 8'h00, 8'h52 ^ 8'h22);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      seen = (rd_addr.size() != 0);
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (!seen || txq.size() != 0 || bus.TX_BYTE !== 8'h06) begin
      errors++; $display("FAIL bp_hold: got read=%0d tx=%0d byte=%h want 1 0 06", seen, txq.size(), bus.TX_BYTE);
    end
    bus.TX_FIFO_FULL = 1'b0;
    wait_tx(2, 100, ok);
    checks++;
    if (txq.size() != 2 || txq[0] !== 8'h06 || txq[1] !== ref_mem[8'h22] || tx_cyc[1] - tx_cyc[0] != 2) begin
      errors++; $display("FAIL bp_release: got %0d bytes %h %h want 06 %h gap 2", txq.size(),
        txq.size() > 0 ? txq[0] : 8'h0, txq.size() > 1 ? txq[1] : 8'h0, ref_mem[8'h22]);
    end
    checks++;
    if (full_viol != 0) begin
      errors++; $display("FAIL bp_write_while_full: got %0d want 0", full_viol);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit seen;
    clear_logs();
    rxq.push_back(8'hA5); rxq.push_back(8'h57); rxq.push_back(8'h10);
    repeat (12) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.RX_FIFO_RD_REQ, bus.TX_FIFO_WR_REQ, bus.REG_WR, bus.REG_RD, bus.TX_BYTE,
         bus.REG_ADDR, bus.REG_WDATA, bus.ERR_CNT} !== 36'h0) begin
      errors++; $display("FAIL midreset_outputs: got err=%h byte=%h addr=%h want all 0", bus.ERR_CNT, bus.TX_BYTE, bus.REG_ADDR);
    end
    RESET = 1'b0;
    ref_err = 0;
    push_frame(8'h57, 8'h44, 8'h21, 8'h57 ^ 8'h44 ^ 8'h21);
    ref_mem[8'h44] = 8'h21;
    wait_tx(1, 200, ok);
    checks++;
    if (txq.size() != 1 || txq[0] !== 8'h06 || wr_addr.size() != 1 || wr_addr[0] !== 8'h44) begin
      errors++; $display("FAIL midreset_next_frame: got %0d tx %0d wr want 1 1", txq.size(), wr_addr.size());
    end
    // Reset while an ACK is held back by a full TX FIFO: it must never go out
    clear_logs();
    bus.TX_FIFO_FULL = 1'b1;
    push_frame(8'h57, 8'h45, 8'h66, 8'h57 ^ 8'h45 ^ 8'h66);
    ref_mem[8'h45] = 8'h66;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      seen = (wr_addr.size() != 0);
    end
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    bus.TX_FIFO_FULL = 1'b0;
    repeat (30) @(negedge CLK);
    checks++;
    if (!seen || txq.size() != 0) begin
      errors++; $display("FAIL midresp_reset: got write=%0d tx=%0d want 1 0", seen, txq.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int first_after;
    clear_logs();
    push_frame(8'h57, 8'h77, 8'hC3, 8'h57 ^ 8'h77 ^ 8'hC3);
    push_frame(8'h52, 8'h77, 8'h00, 8'h52 ^ 8'h77);
    ref_mem[8'h77] = 8'hC3;
    wait_tx(3, 300, ok);
    checks++;
    if (txq.size() != 3 || txq[0] !== 8'h06 || txq[1] !== 8'h06 || txq[2] !== 8'hC3) begin
      errors++; $display("FAIL b2b_tx: got %0d bytes want 06 06 c3", txq.size());
    end
    first_after = -1;
    if (tx_cyc.size() > 0)
      foreach (rdreq_cyc[i])
        if (first_after < 0 && rdreq_cyc[i] > tx_cyc[0]) first_after = rdreq_cyc[i];
    checks++;
    if (tx_cyc.size() == 0 || first_after - tx_cyc[0] != 2) begin
      errors++; $display("FAIL b2b_hunt_resume: got %0d want 2", (tx_cyc.size() == 0) ? -1 : first_after - tx_cyc[0]);
    end
    checks++;
    if (excl_viol != 0) begin
      errors++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", excl_viol);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int kind;
      int ng;
      bit ok, m;
      logic [7:0] c, a, d, k, g;
      logic [7:0] exp_tx[$];
      bit exp_wr, exp_rd;
      clear_logs();
      kind = $urandom_range(0, 4);
      a = 8'($urandom); d = 8'($urandom);
      if (kind == 1) c = 8'h52;
      else if (kind == 3) begin
        c = 8'($urandom);
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
      end else c = 8'h57;
      k = c ^ a ^ d;
      if (kind == 2) k = k ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 4) begin
        ng = $urandom_range(1, 3);
        for (int i = 0; i < ng; i++) begin
          g = 8'($urandom);
          if (g == 8'hA5) g = 8'h00;
          rxq.push_back(g);
        end
      end
      push_frame(c, a, d, k);
      // Reference: frame rules at the byte level
      exp_wr = 0; exp_rd = 0;
      if ((k == (c ^ a ^ d)) && (c == 8'h57)) begin
        exp_tx.push_back(8'h06); exp_wr = 1; ref_mem[a] = d;
      end else if ((k == (c ^ a ^ d)) && (c == 8'h52)) begin
        exp_tx.push_back(8'h06); exp_tx.push_back(ref_mem[a]); exp_rd = 1;
      end else begin
        exp_tx.push_back(8'h15);
        ref_err = (ref_err == 255) ? 255 : ref_err + 1;
      end
      wait_tx(exp_tx.size(), 300, ok);
      m = ok && (txq.size() == exp_tx.size());
      if (m) foreach (exp_tx[i]) if (txq[i] !== exp_tx[i]) m = 0;
      checks++;
      if (!m) begin
        errors++; $display("FAIL rand_tx[%0d]: got %0d bytes first %h want %0d bytes first %h", f,
          txq.size(), txq.size() ? txq[0] : 8'h0, exp_tx.size(), exp_tx[0]);
      end
      checks++;
      if ((wr_addr.size() != int'(exp_wr)) || (rd_addr.size() != int'(exp_rd)) ||
          (exp_wr && (wr_addr[0] !== a || wr_data[0] !== d)) || (exp_rd && rd_addr[0] !== a)) begin
        errors++; $display("FAIL rand_reg[%0d]: got wr=%0d rd=%0d want wr=%0d rd=%0d addr %h", f,
          wr_addr.size(), rd_addr.size(), exp_wr, exp_rd, a);
      end
      checks++;
      if (bus.ERR_CNT !== 8'(ref_err)) begin
        errors++; $display("FAIL rand_err_cnt[%0d]: got %0d want %0d", f, bus.ERR_CNT, ref_err);
      end
    end
  endtask

  task automatic test_err_saturation();
    bit ok;
    for (int f = 0; f < 258; f++) begin
      clear_logs();
      push_frame(8'h57, 8'h00, 8'h00, 8'h01);
      ref_err = (ref_err == 255) ? 255 : ref_err + 1;
      wait_tx(1, 200, ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL sat_wait[%0d]: got no nak want 15", f);
        break;
      end
      if (f == 200 || f == 257) begin
        checks++;
        if (bus.ERR_CNT !== 8'(ref_err)) begin
          errors++; $display("FAIL sat_err_cnt[%0d]: got %0d want %0d", f, bus.ERR_CNT, ref_err);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = dflt(i);
    test_reset();
    test_write();
    test_read();
    test_bad_checksum();
    test_garbage();
    test_timeout();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    test_err_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
